// File: rtl/freq_meter_pkg.sv
// Shared types and defaults for the clock frequency meter.
// Default gate is one second of the 12 MHz board clock.
package freq_meter_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    localparam int unsigned BOARD_CLK_HZ    = 12_000_000;
    localparam int unsigned DEF_GATE_CYCLES = BOARD_CLK_HZ;
    localparam int unsigned DEF_CNT_W       = 24;

    // Gate counter width: enough bits to hold 0 .. gate_cycles-1.
    function automatic int unsigned gate_w(input int unsigned gate_cycles);
        return (gate_cycles <= 2) ? 1 : $clog2(gate_cycles);
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer plus rising-edge detect for an asynchronous input.
// Reusable for push-buttons and other slow asynchronous pins.
module sync_edge_detect (
    input  logic clk,
    input  logic resetb,
    input  logic i_async,
    output logic o_rise_c
);

    logic r_sync1;
    logic r_sync2;
    logic r_sync3;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= i_async;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign o_rise_c = r_sync2 & ~r_sync3;

endmodule

// File: rtl/clk_freq_meter.sv
// Counts rising edges of an asynchronous signal over back-to-back gate windows
// of GATE_CYCLES clk cycles and publishes each result with a one-cycle strobe.
module clk_freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic             sig_in,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             count_valid,
    output logic             overflow,
    output logic             busy
);

    localparam int unsigned           GATE_W    = gate_w(GATE_CYCLES);
    localparam logic [GATE_W-1:0]     GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]      CNT_MAX   = {CNT_W{1'b1}};

    state_t             r_state;
    logic [GATE_W-1:0]  r_gate_cnt;
    logic [CNT_W-1:0]   r_edge_cnt;
    logic               r_sat;
    logic [CNT_W-1:0]   r_count;
    logic               r_overflow;
    logic               r_count_valid;
    logic               r_busy;

    state_t             w_state_nxt;
    logic [GATE_W-1:0]  w_gate_nxt;
    logic [CNT_W-1:0]   w_edge_nxt;
    logic               w_sat_nxt;
    logic [CNT_W-1:0]   w_count_nxt;
    logic               w_overflow_nxt;
    logic               w_count_valid_nxt;
    logic               w_busy_nxt;

    logic               w_rise;
    logic               w_at_max;
    logic [CNT_W-1:0]   w_edge_inc;
    logic               w_sat_hit;

    sync_edge_detect u_sync (
        .clk      (clk),
        .resetb   (resetb),
        .i_async  (sig_in),
        .o_rise_c (w_rise)
    );

    // Saturating edge increment; hitting the ceiling marks the window as overflowed.
    assign w_at_max   = (r_edge_cnt == CNT_MAX);
    assign w_edge_inc = (w_rise && !w_at_max) ? (r_edge_cnt + CNT_W'(1)) : r_edge_cnt;
    assign w_sat_hit  = w_rise && w_at_max;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_state       <= IDLE;
            r_gate_cnt    <= '0;
            r_edge_cnt    <= '0;
            r_sat         <= 1'b0;
            r_count       <= '0;
            r_overflow    <= 1'b0;
            r_count_valid <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_gate_cnt    <= w_gate_nxt;
            r_edge_cnt    <= w_edge_nxt;
            r_sat         <= w_sat_nxt;
            r_count       <= w_count_nxt;
            r_overflow    <= w_overflow_nxt;
            r_count_valid <= w_count_valid_nxt;
            r_busy        <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_gate_nxt        = r_gate_cnt;
        w_edge_nxt        = r_edge_cnt;
        w_sat_nxt         = r_sat;
        w_count_nxt       = r_count;
        w_overflow_nxt    = r_overflow;
        w_count_valid_nxt = 1'b0;
        w_busy_nxt        = 1'b0;

        case (r_state)
            IDLE: begin
                w_gate_nxt = '0;
                w_edge_nxt = '0;
                w_sat_nxt  = 1'b0;
                if (enable) begin
                    w_state_nxt = MEASURE;
                    w_busy_nxt  = 1'b1;
                end
            end
            MEASURE: begin
                if (!enable) begin
                    // Abandon: the partial window is discarded, last result is kept.
                    w_state_nxt = IDLE;
                    w_gate_nxt  = '0;
                    w_edge_nxt  = '0;
                    w_sat_nxt   = 1'b0;
                end else if (r_gate_cnt == GATE_LAST) begin
                    w_busy_nxt        = 1'b1;
                    w_count_nxt       = w_edge_inc;
                    w_overflow_nxt    = r_sat | w_sat_hit;
                    w_count_valid_nxt = 1'b1;
                    w_gate_nxt        = '0;
                    w_edge_nxt        = '0;
                    w_sat_nxt         = 1'b0;
                end else begin
                    w_busy_nxt = 1'b1;
                    w_gate_nxt = r_gate_cnt + GATE_W'(1);
                    w_edge_nxt = w_edge_inc;
                    w_sat_nxt  = r_sat | w_sat_hit;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gate_nxt  = '0;
                w_edge_nxt  = '0;
                w_sat_nxt   = 1'b0;
            end
        endcase
    end

    assign count       = r_count;
    assign count_valid = r_count_valid;
    assign overflow    = r_overflow;
    assign busy        = r_busy;

endmodule

// File: tb/tb_clk_freq_meter.sv
// Bench for clk_freq_meter: two instances (8-bit and 5-bit counters) share stimulus
// and are compared every cycle against a window-level model of edge counting.
module tb_clk_freq_meter;

    localparam int G = 100;

    logic       clk = 1'b0;
    logic       resetb;
    logic       sig_in = 1'b0;
    logic       enable = 1'b0;

    logic [7:0] count8;
    logic [4:0] count5;
    logic       cv8, cv5, ov8, ov5, busy8, busy5;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    clk_freq_meter #(.GATE_CYCLES(G), .CNT_W(8)) u_dut8 (
        .clk         (clk),
        .resetb      (resetb),
        .sig_in      (sig_in),
        .enable      (enable),
        .count       (count8),
        .count_valid (cv8),
        .overflow    (ov8),
        .busy        (busy8)
    );

    clk_freq_meter #(.GATE_CYCLES(G), .CNT_W(5)) u_dut5 (
        .clk         (clk),
        .resetb      (resetb),
        .sig_in      (sig_in),
        .enable      (enable),
        .count       (count5),
        .count_valid (cv5),
        .overflow    (ov5),
        .busy        (busy5)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // sig_in generator: 0 = hold low, 1 = hold high, 2 = periodic hi/lo phases, 3 = random
    int gen_mode = 3;
    int gen_hi   = 5;
    int gen_lo   = 5;
    int g_cnt    = 0;

    always @(negedge clk) begin
        case (gen_mode)
            0: begin sig_in = 1'b0; g_cnt = 0; end
            1: begin sig_in = 1'b1; g_cnt = 0; end
            2: begin
                g_cnt++;
                if (sig_in && g_cnt >= gen_hi) begin
                    sig_in = 1'b0; g_cnt = 0;
                end else if (!sig_in && g_cnt >= gen_lo) begin
                    sig_in = 1'b1; g_cnt = 0;
                end
            end
            default: sig_in = 1'($urandom_range(0, 1));
        endcase
    end

    // Reference model: window bookkeeping with an unbounded integer edge tally,
    // clamped to the counter range only when a result is published.
    bit m_active;
    int m_pos;
    int m_edges;
    bit h0, h1, h2;       // sig_in as sampled on the last three edges
    int e_count8, e_count5;
    bit e_valid, e_ovf8, e_ovf5, e_busy;

    always @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            m_active = 0; m_pos = 0; m_edges = 0;
            h0 = 0; h1 = 0; h2 = 0;
            e_count8 = 0; e_count5 = 0;
            e_valid = 0; e_ovf8 = 0; e_ovf5 = 0; e_busy = 0;
        end else begin
            bit rise;
            // A sig_in edge reaches the counter after two synchronizer stages.
            rise    = h1 & ~h2;
            e_valid = 0;
            if (!m_active) begin
                if (enable) begin
                    m_active = 1; m_pos = 0; m_edges = 0;
                end
            end else if (!enable) begin
                m_active = 0;
            end else begin
                m_edges += int'(rise);
                if (m_pos == G - 1) begin
                    e_valid  = 1;
                    e_count8 = (m_edges > 255) ? 255 : m_edges;
                    e_ovf8   = (m_edges > 255);
                    e_count5 = (m_edges > 31) ? 31 : m_edges;
                    e_ovf5   = (m_edges > 31);
                    m_pos    = 0;
                    m_edges  = 0;
                end else begin
                    m_pos++;
                end
            end
            e_busy = m_active;
            h2 = h1; h1 = h0; h0 = sig_in;
        end
    end

    always @(negedge clk) begin
        chk("count8",   32'(count8), 32'(e_count8));
        chk("ovf8",     32'(ov8),    32'(e_ovf8));
        chk("valid8",   32'(cv8),    32'(e_valid));
        chk("busy8",    32'(busy8),  32'(e_busy));
        chk("count5",   32'(count5), 32'(e_count5));
        chk("ovf5",     32'(ov5),    32'(e_ovf5));
        chk("valid5",   32'(cv5),    32'(e_valid));
        chk("busy5",    32'(busy5),  32'(e_busy));
    end

    task automatic wait_pulse(input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cv8 && n < limit);
        if (!cv8) begin
            total++;
            bad++;
            $display("FAIL pulse_timeout: no count_valid within %0d cycles, expected one", limit);
        end
    endtask

    initial begin
        int n;
        resetb = 1'b1;
        #1 resetb = 1'b0;

        // Reset with random inputs
        repeat (3) begin
            @(negedge clk);
            enable = 1'($urandom_range(0, 1));
        end
        chk("reset_count", 32'(count8), 32'd0);
        chk("reset_busy",  32'(busy8),  32'd0);
        @(negedge clk);
        enable = 1'b0; gen_mode = 2; gen_hi = 5; gen_lo = 5;
        #2 resetb = 1'b1;
        repeat (20) @(negedge clk);

        // Period 10 square wave
        enable = 1'b1;
        wait_pulse(300, n);
        chk("first_latency", 32'(n), 32'd101);
        chk("p10_count8", 32'(count8), 32'd10);
        chk("p10_ovf8",   32'(ov8),    32'd0);
        wait_pulse(300, n);
        chk("period", 32'(n), 32'd100);
        chk("p10_count5", 32'(count5), 32'd10);

        // Period 2 saturates the 5-bit counter
        gen_hi = 1; gen_lo = 1;
        wait_pulse(300, n);
        wait_pulse(300, n);
        chk("p2_count5", 32'(count5), 32'd31);
        chk("p2_ovf5",   32'(ov5),    32'd1);
        chk("p2_count8", 32'(count8), 32'd50);
        chk("p2_ovf8",   32'(ov8),    32'd0);

        gen_hi = 5; gen_lo = 5;
        wait_pulse(300, n);
        wait_pulse(300, n);
        chk("back_count5", 32'(count5), 32'd10);
        chk("back_ovf5",   32'(ov5),    32'd0);

        // Abandon mid-window
        repeat (50) @(negedge clk);
        enable = 1'b0;
        repeat (60) @(negedge clk);
        chk("abandon_busy",  32'(busy8),  32'd0);
        chk("abandon_count", 32'(count8), 32'd10);
        enable = 1'b1;
        wait_pulse(300, n);
        chk("rearm_latency", 32'(n), 32'd101);
        chk("rearm_count",   32'(count8), 32'd10);

        // Drop enable on the final window cycle
        repeat (99) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        chk("last_cycle_drop_valid", 32'(cv8),   32'd0);
        chk("last_cycle_drop_busy",  32'(busy8), 32'd0);
        enable = 1'b1;

        // Constant input
        gen_mode = 1;
        wait_pulse(300, n);
        wait_pulse(300, n);
        chk("hold1_count", 32'(count8), 32'd0);
        gen_mode = 0;
        wait_pulse(300, n);
        wait_pulse(300, n);
        chk("hold0_period", 32'(n), 32'd100);
        chk("hold0_count",  32'(count5), 32'd0);

        // Reset at window cycle 70
        gen_mode = 2;
        wait_pulse(300, n);
        wait_pulse(300, n);
        repeat (70) @(negedge clk);
        #2 resetb = 1'b0;
        gen_mode = 0;
        #1;
        chk("midreset_count", 32'(count8), 32'd0);
        chk("midreset_busy",  32'(busy8),  32'd0);
        chk("midreset_valid", 32'(cv8),    32'd0);
        repeat (3) @(negedge clk);
        gen_mode = 2;
        #2 resetb = 1'b1;
        wait_pulse(300, n);
        chk("post_reset_latency", 32'(n), 32'd101);
        chk("post_reset_count",   32'(count8), 32'd10);

        // Randomized segments
        for (int seg = 0; seg < 30; seg++) begin
            @(negedge clk);
            case ($urandom_range(0, 5))
                0: gen_mode = 0;
                1: gen_mode = 1;
                default: begin
                    gen_mode = 2;
                    gen_hi = $urandom_range(2, 12);
                    gen_lo = $urandom_range(2, 12);
                end
            endcase
            enable = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 7) == 0) begin
                #2 resetb = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                #2 resetb = 1'b1;
            end
            repeat ($urandom_range(20, 320)) @(negedge clk);
        end

        enable = 1'b0;
        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
